// File: rtl/bfm_apb_pkg.sv
// Shared definitions for the AHB-Lite to APB4 bridge BFM: FSM states,
// AHB transfer codes and the APB4 byte-strobe helper.
package bfm_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  // Reads never assert strobes; sizes above word are rejected before use.
  function automatic logic [3:0] pstrb_gen(input logic       write,
                                           input logic [2:0] size,
                                           input logic [1:0] addr);
    logic [3:0] strb;
    strb = '0;
    if (write) begin
      case (size)
        HSIZE_BYTE: strb = 4'b0001 << addr;
        HSIZE_HALF: strb = 4'b0011 << {addr[1], 1'b0};
        default:    strb = 4'hF;
      endcase
    end
    return strb;
  endfunction

endpackage

// File: rtl/bfm_ahbtoapb4_bridge_if.sv
// AHB-Lite slave side plus APB4 master side of the bridge, grouped in one bundle.
// slave: the bridge's view; master: the surrounding AHB master / APB slaves.
interface bfm_ahbtoapb4_bridge_if #(
  parameter int unsigned NSLOTS = 16,
  parameter int unsigned ADDR_W = 32
);
  logic              HSEL;
  logic              HWRITE;
  logic [31:0]       HADDR;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA;
  logic              HREADYIN;
  logic              HREADYOUT;
  logic [1:0]        HTRANS;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic              HMASTLOCK;
  logic [3:0]        HPROT;
  logic              HRESP;
  logic [NSLOTS-1:0] PSEL;
  logic [ADDR_W-1:0] PADDR;
  logic              PWRITE;
  logic              PENABLE;
  logic [31:0]       PWDATA;
  logic [3:0]        PSTRB;
  logic [2:0]        PPROT;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [15:0]       ERR_CNT;

  modport slave (
    input  HSEL, HWRITE, HADDR, HWDATA, HREADYIN, HTRANS, HSIZE, HBURST,
           HMASTLOCK, HPROT, PRDATA, PREADY, PSLVERR,
    output HRDATA, HREADYOUT, HRESP, PSEL, PADDR, PWRITE, PENABLE, PWDATA,
           PSTRB, PPROT, ERR_CNT
  );

  modport master (
    output HSEL, HWRITE, HADDR, HWDATA, HREADYIN, HTRANS, HSIZE, HBURST,
           HMASTLOCK, HPROT, PRDATA, PREADY, PSLVERR,
    input  HRDATA, HREADYOUT, HRESP, PSEL, PADDR, PWRITE, PENABLE, PWDATA,
           PSTRB, PPROT, ERR_CNT
  );
endinterface

// File: rtl/bfm_apb_slot_decode.sv
// Decodes the 4-bit slot field of HADDR into a one-hot APB select and
// flags indices that have no slot behind them.
module bfm_apb_slot_decode #(
  parameter int unsigned NSLOTS   = 16,
  parameter int unsigned SLOT_LSB = 24
) (
  input  logic [31:0]       i_haddr,
  output logic [NSLOTS-1:0] o_psel,
  output logic              o_oor
);
  logic [3:0] w_idx;
  logic       w_unused_addr;

  assign w_idx         = i_haddr[SLOT_LSB +: 4];
  assign w_unused_addr = ^i_haddr;

  always_comb begin
    o_psel = '0;
    for (int unsigned i = 0; i < NSLOTS; i++) begin
      o_psel[i] = (w_idx == 4'(i));
    end
  end

  assign o_oor = ({1'b0, w_idx} >= 5'(NSLOTS));

endmodule

// File: rtl/bfm_ahbtoapb4_bridge.sv
// AHB-Lite to APB4 bridge BFM: slot decode, APB4 strobes/protection, two-cycle
// AHB error response, PREADY timeout and a saturating error counter.
module bfm_ahbtoapb4_bridge
  import bfm_apb_pkg::*;
#(
  parameter int          TPD      = 1,
  parameter int unsigned NSLOTS   = 16,
  parameter int unsigned SLOT_LSB = 24,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned TIMEOUT  = 256,
  parameter logic        NONSEC   = 1'b1
) (
  input logic                    HCLK,
  input logic                    HRESETN,
  bfm_ahbtoapb4_bridge_if.slave  bus
);
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  if (NSLOTS < 1 || NSLOTS > 16 || TPD < 0) begin : g_param_check
    $error("bfm_ahbtoapb4_bridge: NSLOTS must be 1..16 and TPD non-negative");
  end

  state_t            r_state, w_next;
  logic [NSLOTS-1:0] r_psel;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [31:0]       r_pwdata;
  logic [3:0]        r_pstrb;
  logic [2:0]        r_pprot;
  logic [15:0]       r_err_cnt;
  logic [CNT_W-1:0]  r_cnt;

  logic [NSLOTS-1:0] w_dec_psel;
  logic              w_dec_oor;
  logic              w_valid, w_bad, w_take, w_setup_go, w_timeout;
  logic              w_unused;

  bfm_apb_slot_decode #(
    .NSLOTS   (NSLOTS),
    .SLOT_LSB (SLOT_LSB)
  ) u_slot_decode (
    .i_haddr (bus.HADDR),
    .o_psel  (w_dec_psel),
    .o_oor   (w_dec_oor)
  );

  assign w_valid    = bus.HSEL & bus.HREADYIN & bus.HTRANS[1];
  assign w_bad      = w_dec_oor | (bus.HSIZE > HSIZE_WORD);
  assign w_timeout  = (TIMEOUT > 0) && !bus.PREADY && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_setup_go = w_take & w_valid & ~w_bad;
  assign w_unused   = ^{bus.HBURST, bus.HMASTLOCK, bus.HPROT[3:2], bus.HTRANS[0], bus.HADDR};

  // w_take marks cycles in which a new AHB address phase may be accepted,
  // letting completion and ERR2 chain straight into the next transfer.
  always_comb begin
    w_next        = r_state;
    w_take        = 1'b0;
    bus.HREADYOUT = 1'b1;
    bus.HRESP     = 1'b0;
    bus.PSEL      = '0;
    bus.PENABLE   = 1'b0;
    bus.PWDATA    = r_pwdata;
    case (r_state)
      ST_IDLE: begin
        w_next = ST_IDLE;
        w_take = 1'b1;
      end
      ST_SETUP: begin
        w_next        = ST_ACCESS;
        bus.HREADYOUT = 1'b0;
        bus.PSEL      = r_psel;
        bus.PWDATA    = bus.HWDATA;
      end
      ST_ACCESS: begin
        bus.HREADYOUT = bus.PREADY & ~bus.PSLVERR;
        bus.PSEL      = r_psel;
        bus.PENABLE   = 1'b1;
        if (bus.PREADY) begin
          if (bus.PSLVERR) begin
            w_next = ST_ERR1;
          end else begin
            w_next = ST_IDLE;
            w_take = 1'b1;
          end
        end else if (w_timeout) begin
          w_next = ST_ERR1;
        end
      end
      ST_ERR1: begin
        w_next        = ST_ERR2;
        bus.HRESP     = 1'b1;
        bus.HREADYOUT = 1'b0;
      end
      ST_ERR2: begin
        w_next    = ST_IDLE;
        w_take    = 1'b1;
        bus.HRESP = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_take && w_valid) begin
      w_next = w_bad ? ST_ERR1 : ST_SETUP;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      r_state   <= ST_IDLE;
      r_psel    <= '0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_pprot   <= '0;
      r_err_cnt <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      if (w_setup_go) begin
        r_psel   <= w_dec_psel;
        r_paddr  <= bus.HADDR[ADDR_W-1:0];
        r_pwrite <= bus.HWRITE;
        r_pstrb  <= pstrb_gen(bus.HWRITE, bus.HSIZE, bus.HADDR[1:0]);
        r_pprot  <= {~bus.HPROT[0], NONSEC, bus.HPROT[1]};
      end
      if (r_state == ST_SETUP) begin
        r_pwdata <= bus.HWDATA;
        r_cnt    <= '0;
      end else if (r_state == ST_ACCESS && !bus.PREADY) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_next == ST_ERR1 && r_err_cnt != '1) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign bus.PADDR   = r_paddr;
  assign bus.PWRITE  = r_pwrite;
  assign bus.PSTRB   = r_pstrb;
  assign bus.PPROT   = r_pprot;
  assign bus.HRDATA  = bus.PRDATA;
  assign bus.ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_bfm_ahbtoapb4_bridge.sv
// Directed bench for bfm_ahbtoapb4_bridge: a 16-slot instance with an 8-cycle
// PREADY timeout and a 4-slot instance for slot decode errors.
module tb_bfm_ahbtoapb4_bridge;
  import bfm_apb_pkg::*;

  logic HCLK;
  logic HRESETN;
  int   n_chk;
  int   n_fail;

  bfm_ahbtoapb4_bridge_if #(.NSLOTS(16), .ADDR_W(32)) ifa ();
  bfm_ahbtoapb4_bridge_if #(.NSLOTS(4),  .ADDR_W(32)) ifb ();

  bfm_ahbtoapb4_bridge #(.NSLOTS(16), .TIMEOUT(8)) dut_a (
    .HCLK    (HCLK),
    .HRESETN (HRESETN),
    .bus     (ifa)
  );

  bfm_ahbtoapb4_bridge #(.NSLOTS(4)) dut_b (
    .HCLK    (HCLK),
    .HRESETN (HRESETN),
    .bus     (ifb)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge HCLK);
  endtask

  task automatic a_addr(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [3:0] prot);
    ifa.HSEL   = 1'b1;
    ifa.HTRANS = HTRANS_NONSEQ;
    ifa.HADDR  = a;
    ifa.HWRITE = w;
    ifa.HSIZE  = sz;
    ifa.HPROT  = prot;
  endtask

  task automatic a_idle();
    ifa.HSEL   = 1'b0;
    ifa.HTRANS = HTRANS_IDLE;
  endtask

  initial begin
    int nacc;
    n_chk  = 0;
    n_fail = 0;
    HRESETN = 1'b0;
    ifa.HSEL = 1'b0; ifa.HWRITE = 1'b0; ifa.HADDR = '0; ifa.HWDATA = '0;
    ifa.HREADYIN = 1'b1; ifa.HTRANS = HTRANS_IDLE; ifa.HSIZE = HSIZE_WORD;
    ifa.HBURST = '0; ifa.HMASTLOCK = 1'b0; ifa.HPROT = 4'b0011;
    ifa.PRDATA = '0; ifa.PREADY = 1'b1; ifa.PSLVERR = 1'b0;
    ifb.HSEL = 1'b0; ifb.HWRITE = 1'b0; ifb.HADDR = '0; ifb.HWDATA = '0;
    ifb.HREADYIN = 1'b1; ifb.HTRANS = HTRANS_IDLE; ifb.HSIZE = HSIZE_WORD;
    ifb.HBURST = '0; ifb.HMASTLOCK = 1'b0; ifb.HPROT = 4'b0011;
    ifb.PRDATA = '0; ifb.PREADY = 1'b1; ifb.PSLVERR = 1'b0;

    // Reset values
    repeat (2) smp();
    chk("rst_hready",  32'(ifa.HREADYOUT), 32'h1);
    chk("rst_hresp",   32'(ifa.HRESP),     32'h0);
    chk("rst_psel",    32'(ifa.PSEL),      32'h0);
    chk("rst_penable", 32'(ifa.PENABLE),   32'h0);
    chk("rst_pwrite",  32'(ifa.PWRITE),    32'h0);
    chk("rst_paddr",   ifa.PADDR,          32'h0);
    chk("rst_pwdata",  ifa.PWDATA,         32'h0);
    chk("rst_pstrb",   32'(ifa.PSTRB),     32'h0);
    chk("rst_pprot",   32'(ifa.PPROT),     32'h0);
    chk("rst_errcnt",  32'(ifa.ERR_CNT),   32'h0);
    @(negedge HCLK) HRESETN = 1'b1;

    // Word write to slot 3, PREADY immediate
    tick(); a_addr(32'h0300_0010, 1'b1, HSIZE_WORD, 4'b0011);
    smp();  chk("wr_addr_psel", 32'(ifa.PSEL), 32'h0);
    tick(); a_idle(); ifa.HWDATA = 32'hDEAD_BEEF;
    smp();
    chk("wr_setup_psel",   32'(ifa.PSEL),      32'h0008);
    chk("wr_setup_pen",    32'(ifa.PENABLE),   32'h0);
    chk("wr_setup_hready", 32'(ifa.HREADYOUT), 32'h0);
    chk("wr_setup_pwdata", ifa.PWDATA,         32'hDEAD_BEEF);
    chk("wr_setup_paddr",  ifa.PADDR,          32'h0300_0010);
    chk("wr_setup_pstrb",  32'(ifa.PSTRB),     32'hF);
    chk("wr_setup_pwrite", 32'(ifa.PWRITE),    32'h1);
    chk("wr_setup_pprot",  32'(ifa.PPROT),     32'b011);
    tick();
    smp();
    chk("wr_acc_psel",   32'(ifa.PSEL),      32'h0008);
    chk("wr_acc_pen",    32'(ifa.PENABLE),   32'h1);
    chk("wr_acc_hready", 32'(ifa.HREADYOUT), 32'h1);
    chk("wr_acc_pwdata", ifa.PWDATA,         32'hDEAD_BEEF);
    tick();
    smp();
    chk("wr_done_psel", 32'(ifa.PSEL),    32'h0);
    chk("wr_done_pen",  32'(ifa.PENABLE), 32'h0);

    // Byte read at slot 5 with three PREADY-low ACCESS cycles
    tick(); a_addr(32'h0500_0002, 1'b0, HSIZE_BYTE, 4'b0001);
    tick(); a_idle(); ifa.PREADY = 1'b0;
    smp();
    chk("rd_setup_psel",   32'(ifa.PSEL),      32'h0020);
    chk("rd_setup_pstrb",  32'(ifa.PSTRB),     32'h0);
    chk("rd_setup_pprot",  32'(ifa.PPROT),     32'b010);
    chk("rd_setup_hready", 32'(ifa.HREADYOUT), 32'h0);
    for (int k = 2; k <= 5; k++) begin
      tick();
      ifa.PREADY = (k == 5);
      ifa.PRDATA = (k == 5) ? 32'h00AB_0000 : 32'h0;
      smp();
      chk("rd_acc_hready", 32'(ifa.HREADYOUT), 32'(k == 5));
      chk("rd_acc_pen",    32'(ifa.PENABLE),   32'h1);
    end
    chk("rd_hrdata", ifa.HRDATA, 32'h00AB_0000);
    tick(); ifa.PRDATA = '0;
    smp();  chk("rd_done_pen", 32'(ifa.PENABLE), 32'h0);

    // Back-to-back writes to slots 1 and 2; the second is a halfword at offset 2
    tick(); a_addr(32'h0100_0000, 1'b1, HSIZE_WORD, 4'b0011);
    tick(); a_idle(); ifa.HWDATA = 32'h1111_1111;
    smp();  chk("b2b_s1_psel", 32'(ifa.PSEL), 32'h0002);
    tick(); a_addr(32'h0200_0002, 1'b1, HSIZE_HALF, 4'b0011);
    smp();
    chk("b2b_s1_pen",    32'(ifa.PENABLE),   32'h1);
    chk("b2b_s1_hready", 32'(ifa.HREADYOUT), 32'h1);
    tick(); a_idle(); ifa.HWDATA = 32'h2222_0000;
    smp();
    chk("b2b_s2_psel",   32'(ifa.PSEL),    32'h0004);
    chk("b2b_s2_pen",    32'(ifa.PENABLE), 32'h0);
    chk("b2b_s2_pstrb",  32'(ifa.PSTRB),   32'b1100);
    chk("b2b_s2_paddr",  ifa.PADDR,        32'h0200_0002);
    chk("b2b_s2_pwdata", ifa.PWDATA,       32'h2222_0000);
    tick();
    smp();  chk("b2b_s2_acc", 32'(ifa.PENABLE), 32'h1);
    tick();

    // PSLVERR on a write to slot 2
    tick(); a_addr(32'h0200_0008, 1'b1, HSIZE_WORD, 4'b0011);
    tick(); a_idle();
    tick(); ifa.PSLVERR = 1'b1;
    smp();
    chk("slverr_acc_hready", 32'(ifa.HREADYOUT), 32'h0);
    chk("slverr_acc_hresp",  32'(ifa.HRESP),     32'h0);
    tick(); ifa.PSLVERR = 1'b0;
    smp();
    chk("slverr_e1_hresp",  32'(ifa.HRESP),     32'h1);
    chk("slverr_e1_hready", 32'(ifa.HREADYOUT), 32'h0);
    chk("slverr_e1_psel",   32'(ifa.PSEL),      32'h0);
    chk("slverr_errcnt",    32'(ifa.ERR_CNT),   32'h1);
    tick();
    smp();
    chk("slverr_e2_hresp",  32'(ifa.HRESP),     32'h1);
    chk("slverr_e2_hready", 32'(ifa.HREADYOUT), 32'h1);
    tick();
    smp();  chk("slverr_idle_hresp", 32'(ifa.HRESP), 32'h0);

    // PREADY held low: access aborted after 8 ACCESS cycles
    tick(); a_addr(32'h0400_0000, 1'b0, HSIZE_WORD, 4'b0011);
    tick(); a_idle(); ifa.PREADY = 1'b0;
    nacc = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      smp();
      if (ifa.PENABLE !== 1'b1) break;
      nacc++;
    end
    chk("tmo_acc_cycles", 32'(nacc),            32'd8);
    chk("tmo_e1_hresp",   32'(ifa.HRESP),       32'h1);
    chk("tmo_e1_hready",  32'(ifa.HREADYOUT),   32'h0);
    chk("tmo_e1_psel",    32'(ifa.PSEL),        32'h0);
    chk("tmo_errcnt",     32'(ifa.ERR_CNT),     32'h2);
    tick(); ifa.PREADY = 1'b1;
    smp();
    chk("tmo_e2_hresp",  32'(ifa.HRESP),     32'h1);
    chk("tmo_e2_hready", 32'(ifa.HREADYOUT), 32'h1);
    tick();

    // Doubleword size is a decode error with no APB access
    tick(); a_addr(32'h0100_0000, 1'b1, 3'b011, 4'b0011);
    tick(); a_idle();
    smp();
    chk("size_e1_psel",  32'(ifa.PSEL),    32'h0);
    chk("size_e1_hresp", 32'(ifa.HRESP),   32'h1);
    chk("size_errcnt",   32'(ifa.ERR_CNT), 32'h3);
    tick(); tick();

    // 4-slot instance: slot 7 has nothing behind it
    tick();
    ifb.HSEL = 1'b1; ifb.HTRANS = HTRANS_NONSEQ; ifb.HADDR = 32'h0700_0000;
    ifb.HWRITE = 1'b1; ifb.HSIZE = HSIZE_WORD;
    smp();  chk("dec_addr_hready", 32'(ifb.HREADYOUT), 32'h1);
    tick(); ifb.HSEL = 1'b0; ifb.HTRANS = HTRANS_IDLE;
    smp();
    chk("dec_e1_psel",   32'(ifb.PSEL),      32'h0);
    chk("dec_e1_hresp",  32'(ifb.HRESP),     32'h1);
    chk("dec_e1_hready", 32'(ifb.HREADYOUT), 32'h0);
    chk("dec_errcnt",    32'(ifb.ERR_CNT),   32'h1);
    tick();
    smp();
    chk("dec_e2_hresp",  32'(ifb.HRESP),     32'h1);
    chk("dec_e2_hready", 32'(ifb.HREADYOUT), 32'h1);
    chk("dec_e2_psel",   32'(ifb.PSEL),      32'h0);
    tick();
    ifb.HSEL = 1'b1; ifb.HTRANS = HTRANS_NONSEQ; ifb.HADDR = 32'h0300_0000;
    tick(); ifb.HSEL = 1'b0; ifb.HTRANS = HTRANS_IDLE;
    smp();  chk("dec_s3_psel", 32'(ifb.PSEL), 32'h8);
    tick(); tick();

    // Reset asserted during a stalled ACCESS
    tick(); a_addr(32'h0600_0000, 1'b1, HSIZE_WORD, 4'b0011);
    tick(); a_idle(); ifa.PREADY = 1'b0;
    tick();
    smp();  chk("mid_acc_pen", 32'(ifa.PENABLE), 32'h1);
    #1 HRESETN = 1'b0;
    #1;
    chk("mid_rst_psel",   32'(ifa.PSEL),      32'h0);
    chk("mid_rst_pen",    32'(ifa.PENABLE),   32'h0);
    chk("mid_rst_hready", 32'(ifa.HREADYOUT), 32'h1);
    chk("mid_rst_hresp",  32'(ifa.HRESP),     32'h0);
    chk("mid_rst_paddr",  ifa.PADDR,          32'h0);
    chk("mid_rst_errcnt", 32'(ifa.ERR_CNT),   32'h0);
    @(negedge HCLK) HRESETN = 1'b1;
    ifa.PREADY = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
